// File: rtl/div_fp64_iter.sv
// Iterative IEEE-754 binary64 divider: radix-2 restoring, one quotient bit per cycle,
// valid/ready on both sides with a single operation in flight.
module div_fp64_iter #(
  parameter logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  rm,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        nv,
  output logic        dz,
  output logic        of,
  output logic        uf,
  output logic        nx
);

  localparam logic [2:0] RmRte = 3'b000;
  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StNorm, StRound, StDone} state_e;

  state_e             state_q;
  logic               in_ready_q, out_valid_q, special_q, sign_q, tiny_q, stk_q;
  logic [63:0]        a_q, b_q, result_q;
  logic [4:0]         flags_q;
  logic [2:0]         rm_q;
  logic signed [13:0] exp_q;
  logic [54:0]        rem_q;
  logic [52:0]        div_q;
  logic [55:0]        quo_q;
  logic [53:0]        sig_q;
  logic [5:0]         cnt_q;

  function automatic logic [5:0] lzc53(input logic [52:0] m);
    lzc53 = 6'd0;
    for (int i = 0; i < 53; i++) if (m[i]) lzc53 = 6'(52 - i);
  endfunction

  // Operand classification and normalisation (subnormals get hidden bit via lzc)
  logic [10:0]        ex1, ex2, ex1_eff, ex2_eff;
  logic [52:0]        m1, m2, m1n, m2n;
  logic [5:0]         lz1, lz2;
  logic signed [13:0] e1n, e2n;
  logic               nan1, nan2, snan1, snan2, inf1, inf2, zero1, zero2, sgn;
  logic               special;
  logic [63:0]        sp_res;
  logic [4:0]         sp_flags;

  always_comb begin
    ex1     = a_q[62:52];
    ex2     = b_q[62:52];
    ex1_eff = (ex1 == 11'd0) ? 11'd1 : ex1;
    ex2_eff = (ex2 == 11'd0) ? 11'd1 : ex2;
    m1      = {ex1 != 11'd0, a_q[51:0]};
    m2      = {ex2 != 11'd0, b_q[51:0]};
    lz1     = lzc53(m1);
    lz2     = lzc53(m2);
    m1n     = m1 << lz1;
    m2n     = m2 << lz2;
    e1n     = $signed({3'b0, ex1_eff}) - 14'sd1023 - $signed({8'b0, lz1});
    e2n     = $signed({3'b0, ex2_eff}) - 14'sd1023 - $signed({8'b0, lz2});
    nan1    = (ex1 == 11'h7FF) && (a_q[51:0] != 52'd0);
    nan2    = (ex2 == 11'h7FF) && (b_q[51:0] != 52'd0);
    snan1   = nan1 && !a_q[51];
    snan2   = nan2 && !b_q[51];
    inf1    = (ex1 == 11'h7FF) && (a_q[51:0] == 52'd0);
    inf2    = (ex2 == 11'h7FF) && (b_q[51:0] == 52'd0);
    zero1   = (a_q[62:0] == 63'd0);
    zero2   = (b_q[62:0] == 63'd0);
    sgn     = a_q[63] ^ b_q[63];
  end

  // Special results; flags ordered {nv, dz, of, uf, nx}
  always_comb begin
    special  = 1'b1;
    sp_res   = 64'd0;
    sp_flags = 5'd0;
    if (nan1 || nan2) begin
      sp_res      = CANON_NAN;
      sp_flags[4] = snan1 | snan2;
    end else if ((inf1 && inf2) || (zero1 && zero2)) begin
      sp_res      = CANON_NAN;
      sp_flags[4] = 1'b1;
    end else if (inf1) begin
      sp_res = {sgn, 11'h7FF, 52'd0};
    end else if (zero1) begin
      sp_res = {sgn, 63'd0};
    end else if (zero2) begin
      sp_res      = {sgn, 11'h7FF, 52'd0};
      sp_flags[3] = 1'b1;
    end else if (inf2) begin
      sp_res = {sgn, 63'd0};
    end else begin
      special = 1'b0;
    end
  end

  logic        ge;
  logic [54:0] rem_nxt;

  always_comb begin
    ge      = rem_q >= {2'b0, div_q};
    rem_nxt = (ge ? rem_q - {2'b0, div_q} : rem_q) << 1;
  end

  // Normalise quotient, then denormalise right when the exponent is below emin
  logic [55:0]        qn;
  logic signed [13:0] en, sh;
  logic [6:0]         sh_c;
  logic [107:0]       wide;
  logic               st, tiny;

  always_comb begin
    qn   = quo_q[55] ? quo_q : quo_q << 1;
    en   = quo_q[55] ? exp_q : exp_q - 14'sd1;
    st   = (|qn[1:0]) | (rem_q != 55'd0);
    tiny = en < -14'sd1022;
    sh   = -14'sd1022 - en;
    sh_c = (sh > 14'sd54) ? 7'd54 : sh[6:0];
    wide = {qn[55:2], 54'd0} >> (tiny ? sh_c : 7'd0);
  end

  logic               g, inc, inexact, ovf, to_inf;
  logic [53:0]        sum;
  logic signed [13:0] be;
  logic [51:0]        frac;
  logic [63:0]        rnd_res;

  always_comb begin
    g       = sig_q[0];
    inexact = g | stk_q;
    unique case (rm_q)
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = sign_q & inexact;
      RmRup:   inc = !sign_q & inexact;
      RmRmm:   inc = g;
      default: inc = g & (stk_q | sig_q[1]);
    endcase
    sum = {1'b0, sig_q[53:1]} + {53'd0, inc};
    if (tiny_q) begin
      // A subnormal that rounds up into bit 52 becomes the minimum normal
      be   = $signed({13'd0, sum[52]});
      frac = sum[51:0];
    end else begin
      be   = exp_q + 14'sd1023 + $signed({13'd0, sum[53]});
      frac = sum[53] ? sum[52:1] : sum[51:0];
    end
    ovf    = !tiny_q && (be >= 14'sd2047);
    to_inf = (rm_q == RmRte) || (rm_q == RmRmm) || ((rm_q == RmRdn) && sign_q) ||
             ((rm_q == RmRup) && !sign_q);
    if (ovf) rnd_res = to_inf ? {sign_q, 11'h7FF, 52'd0} : {sign_q, 63'h7FEF_FFFF_FFFF_FFFF};
    else     rnd_res = {sign_q, be[10:0], frac};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
      flags_q     <= 5'd0;
      special_q   <= 1'b0;
      sign_q      <= 1'b0;
      tiny_q      <= 1'b0;
      stk_q       <= 1'b0;
      a_q         <= 64'd0;
      b_q         <= 64'd0;
      rm_q        <= RmRte;
      exp_q       <= 14'sd0;
      rem_q       <= 55'd0;
      div_q       <= 53'd0;
      quo_q       <= 56'd0;
      sig_q       <= 54'd0;
      cnt_q       <= 6'd0;
    end else begin
      unique case (state_q)
        StIdle: if (in_valid) begin
          a_q        <= src1;
          b_q        <= src2;
          rm_q       <= (rm > RmRmm) ? RmRte : rm;
          in_ready_q <= 1'b0;
          state_q    <= StPrep;
        end
        StPrep: begin
          special_q <= special;
          sign_q    <= sgn;
          if (special) begin
            result_q <= sp_res;
            flags_q  <= sp_flags;
            state_q  <= StRound;
          end else begin
            rem_q   <= {2'b0, m1n};
            div_q   <= m2n;
            exp_q   <= e1n - e2n;
            quo_q   <= 56'd0;
            cnt_q   <= 6'd0;
            state_q <= StIter;
          end
        end
        StIter: begin
          quo_q <= {quo_q[54:0], ge};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd55) state_q <= StNorm;
        end
        StNorm: begin
          exp_q   <= en;
          tiny_q  <= tiny;
          sig_q   <= wide[107:54];
          stk_q   <= st | (|wide[53:0]);
          state_q <= StRound;
        end
        StRound: begin
          if (!special_q) begin
            result_q <= rnd_res;
            flags_q  <= {1'b0, 1'b0, ovf, tiny_q & inexact, inexact | ovf};
          end
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign {nv, dz, of, uf, nx} = flags_q;

endmodule

// File: tb/tb_div_fp64_iter.sv
// Directed bench for div_fp64_iter: expected results queued at issue, checked at retire.
module tb_div_fp64_iter;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  rm;
  logic [63:0] src1, src2, result;
  logic        nv, dz, of, uf, nx;

  div_fp64_iter dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .rm(rm),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .nv(nv), .dz(dz), .of(of), .uf(uf), .nx(nx)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [4:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  localparam logic [63:0] Canon = 64'h7FF8_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] r, input logic [63:0] res, input logic [4:0] flg,
                       input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.flg = flg; e.lat = lat;
    sb.push_back(e);
    src1 = a; src2 = b; rm = r; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({tag, " in_ready low"}, 64'(in_ready), 64'd0);
  endtask

  task automatic collect(input int hold);
    exp_t        e;
    int          cyc;
    logic [63:0] r0;
    logic [4:0]  f0;
    e   = sb.pop_front();
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (!out_valid) begin
      check({e.tag, " timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    check({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
    check({e.tag, " result"}, result, e.res);
    check({e.tag, " flags"}, 64'({nv, dz, of, uf, nx}), 64'(e.flg));
    r0 = result;
    f0 = {nv, dz, of, uf, nx};
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check({e.tag, " hold result"}, result, r0);
      check({e.tag, " hold flags"}, 64'({nv, dz, of, uf, nx}), 64'(f0));
      check({e.tag, " hold valid/ready"}, 64'({out_valid, in_ready}), 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({e.tag, " retire valid/ready"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rm = 3'd0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset ready/valid", 64'({in_ready, out_valid}), 64'b10);
    check("reset result", result, 64'd0);
    check("reset flags", 64'({nv, dz, of, uf, nx}), 64'd0);

    issue("1.5/0.5 rte", 64'h3FF8_0000_0000_0000, 64'h3FE0_0000_0000_0000, 3'd0,
          64'h4008_0000_0000_0000, 5'b00000, 59);
    collect(0);
    issue("1/3 rte", 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd0,
          64'h3FD5_5555_5555_5555, 5'b00001, 59);
    collect(10);
    issue("1/3 rup", 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd3,
          64'h3FD5_5555_5555_5556, 5'b00001, 59);
    collect(0);
    issue("1/3 rtz", 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd1,
          64'h3FD5_5555_5555_5555, 5'b00001, 59);
    collect(0);
    issue("-1/3 rdn", 64'hBFF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd2,
          64'hBFD5_5555_5555_5556, 5'b00001, 59);
    collect(0);
    issue("1/3 rm=7", 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd7,
          64'h3FD5_5555_5555_5555, 5'b00001, 59);
    collect(0);

    issue("1/+0", 64'h3FF0_0000_0000_0000, 64'h0, 3'd0, 64'h7FF0_0000_0000_0000, 5'b01000, 2);
    collect(0);
    issue("0/0", 64'h0, 64'h0, 3'd0, Canon, 5'b10000, 2);
    collect(0);
    issue("snan/1", 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 3'd0, Canon, 5'b10000, 2);
    collect(0);

    issue("max/0.5 rtz", 64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 3'd1,
          64'h7FEF_FFFF_FFFF_FFFF, 5'b00101, 59);
    collect(0);
    issue("max/0.5 rte", 64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 3'd0,
          64'h7FF0_0000_0000_0000, 5'b00101, 59);
    collect(0);

    issue("minsub/2", 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000, 3'd0,
          64'h0, 5'b00011, 59);
    collect(0);
    issue("minnorm/2", 64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0,
          64'h0008_0000_0000_0000, 5'b00000, 59);
    collect(0);
    issue("minsub/0.5", 64'h0000_0000_0000_0001, 64'h3FE0_0000_0000_0000, 3'd0,
          64'h0000_0000_0000_0002, 5'b00000, 59);
    collect(0);

    // Reset mid-operation: the aborted divide must never produce a result
    src1 = 64'h3FF0_0000_0000_0000; src2 = 64'h4008_0000_0000_0000; rm = 3'd0;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort ready/valid", 64'({in_ready, out_valid}), 64'b10);
    check("abort result", result, 64'd0);
    repeat (40) @(posedge clock);
    #1 check("abort stays idle", 64'({in_ready, out_valid}), 64'b10);

    issue("post-reset 1.5/0.5", 64'h3FF8_0000_0000_0000, 64'h3FE0_0000_0000_0000, 3'd0,
          64'h4008_0000_0000_0000, 5'b00000, 59);
    collect(0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
